spi_frame_transmitter: RTL and testbench

SPI_FRAME_TRANSMITTER -- requirements
Module: spi_frame_transmitter

---
 rtl/spi_tx_pkg.sv | 16 +
 rtl/spi_half_period_timer.sv | 29 ++
 rtl/spi_frame_transmitter.sv | 132 +++++++++++++
 tb/tb_spi_frame_transmitter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_tx_pkg.sv
// rtl/spi_tx_pkg.sv - shared state encoding and parameter defaults for the SPI frame transmitter
package spi_tx_pkg;

    localparam int FRAME_BYTES_DEF = 3;
    localparam int CLK_DIV_DEF     = 3;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE      = 3'd0;
    localparam spi_state_t ST_CS_SETUP  = 3'd1;
    localparam spi_state_t ST_SCLK_HIGH = 3'd2;
    localparam spi_state_t ST_SCLK_LOW  = 3'd3;
    localparam spi_state_t ST_BYTE_GAP  = 3'd4;
    localparam spi_state_t ST_CS_GUARD  = 3'd5;

endpackage

// File: rtl/spi_half_period_timer.sv
// rtl/spi_half_period_timer.sv - counts CLK_DIV cycles per state and flags the last one
module spi_half_period_timer
    import spi_tx_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Saturates on the terminal count so a state that waits on something else stays ticking
    always_ff @(posedge clk) begin
        if (reset || reload) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_frame_transmitter.sv
// rtl/spi_frame_transmitter.sv - SPI mode-1 frame transmitter; SPI_TX_MISO_CAPTURE_EN adds MISO capture
module spi_frame_transmitter
    import spi_tx_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int CLK_DIV     = CLK_DIV_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [8*FRAME_BYTES-1:0] tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     tx_done,
    output logic                     spi_clk,
    output logic                     spi_mosi,
    output logic                     spi_cs_n,
    input  logic                     spi_miso,
    output logic [8*FRAME_BYTES-1:0] rx_data
);

    localparam int NBITS = 8 * FRAME_BYTES;
    localparam int BW    = $clog2(NBITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

    spi_state_t       state;
    spi_state_t       state_next;
    logic             tick;
    logic             accept;
    logic             last_bit;
    logic             byte_end;
    logic             enter_high;
    logic             enter_guard;
    logic [NBITS-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic             mosi_q;
    logic             done_q;

    assign accept      = tx_valid && (state == ST_IDLE);
    assign last_bit    = (bit_cnt == LAST_BIT);
    assign byte_end    = (bit_cnt[2:0] == 3'd7);
    assign enter_high  = (state_next == ST_SCLK_HIGH) && (state != ST_SCLK_HIGH);
    assign enter_guard = (state_next == ST_CS_GUARD) && (state != ST_CS_GUARD);

    spi_half_period_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .reload (state_next != state),
        .tick   (tick)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (accept) state_next = ST_CS_SETUP;
            ST_CS_SETUP:  if (tick) state_next = ST_SCLK_HIGH;
            ST_SCLK_HIGH: if (tick) state_next = ST_SCLK_LOW;
            ST_SCLK_LOW: begin
                // The last-bit test comes first so a one-byte frame never enters the gap
                if (tick) begin
                    if (last_bit)      state_next = ST_CS_GUARD;
                    else if (byte_end) state_next = ST_BYTE_GAP;
                    else               state_next = ST_SCLK_HIGH;
                end
            end
            ST_BYTE_GAP:  if (tick) state_next = ST_SCLK_HIGH;
            ST_CS_GUARD:  if (tick) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= enter_guard;
            if (accept) begin
                shreg   <= tx_data;
                bit_cnt <= '0;
            end
            if (enter_high) begin
                mosi_q <= shreg[NBITS-1];
                shreg  <= {shreg[NBITS-2:0], 1'b0};
            end
            if (state == ST_SCLK_LOW && tick && !last_bit) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (enter_guard) begin
                mosi_q <= 1'b0;
            end
        end
    end

    assign tx_ready = (state == ST_IDLE);
    assign tx_done  = done_q;
    assign spi_clk  = (state == ST_SCLK_HIGH);
    assign spi_mosi = mosi_q;
    assign spi_cs_n = (state == ST_IDLE) || (state == ST_CS_GUARD);

`ifdef SPI_TX_MISO_CAPTURE_EN
    logic [NBITS-1:0] rx_shift;
    logic [NBITS-1:0] rx_q;

    // Sampled on the last SCLK_HIGH cycle, i.e. the edge on which sclk falls
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_shift <= '0;
            rx_q     <= '0;
        end else begin
            if (state == ST_SCLK_HIGH && tick) begin
                rx_shift <= {rx_shift[NBITS-2:0], spi_miso};
            end
            if (enter_guard) begin
                rx_q <= rx_shift;
            end
        end
    end

    assign rx_data = rx_q;
`else
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_frame_transmitter.sv
// tb/tb_spi_frame_transmitter.sv - directed checks of the SPI frame transmitter at default and minimal sizes
module tb_spi_frame_transmitter;

`ifdef SPI_TX_MISO_CAPTURE_EN
    localparam logic [23:0] RX_EXP = 24'h5A0FF0;
`else
    localparam logic [23:0] RX_EXP = 24'h000000;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [23:0] tx_data;
    logic        tx_valid, tx_ready, tx_done, spi_clk, spi_mosi, spi_cs_n, spi_miso;
    logic [23:0] rx_data;

    logic [7:0]  tx_data1, rx_data1;
    logic        tx_valid1, tx_ready1, tx_done1, spi_clk1, spi_mosi1, spi_cs_n1;

    spi_frame_transmitter dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .rx_data(rx_data)
    );

    spi_frame_transmitter #(.FRAME_BYTES(1), .CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .tx_done(tx_done1), .spi_clk(spi_clk1), .spi_mosi(spi_mosi1),
        .spi_cs_n(spi_cs_n1), .spi_miso(1'b0), .rx_data(rx_data1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Slave/MISO model for dut and slave model for dut1, sampled on the falling clk edge
    int          done_cnt = 0, low_run = 0, last_low = 0, high_run = 0, last_high = 0, ready_bad = 0;
    logic [31:0] dec = '0;
    logic        prev_sclk = 1'b0, prev_cs = 1'b1;
    logic [23:0] miso_pat = '0;
    int          done_cnt1 = 0, rise_cnt1 = 0, low_run1 = 0, last_low1 = 0;
    logic [31:0] dec1 = '0;
    logic        prev_sclk1 = 1'b0, prev_cs1 = 1'b1;

    initial spi_miso = 1'b0;

    always @(negedge clk) begin
        if (spi_cs_n && !prev_cs) begin last_low = low_run; high_run = 0; end
        if (!spi_cs_n && prev_cs) begin last_high = high_run; low_run = 0; miso_pat = 24'h5A0FF0; end
        if (spi_cs_n) high_run++; else low_run++;
        if (tx_ready && !spi_cs_n) ready_bad++;
        if (spi_clk && !prev_sclk) begin spi_miso = miso_pat[23]; miso_pat = {miso_pat[22:0], 1'b0}; end
        if (!spi_clk && prev_sclk) dec = {dec[30:0], spi_mosi};
        if (tx_done) done_cnt++;
        prev_sclk = spi_clk;
        prev_cs   = spi_cs_n;

        if (spi_cs_n1 && !prev_cs1) last_low1 = low_run1;
        if (!spi_cs_n1 && prev_cs1) low_run1 = 0;
        if (!spi_cs_n1) low_run1++;
        if (spi_clk1 && !prev_sclk1) rise_cnt1++;
        if (!spi_clk1 && prev_sclk1) dec1 = {dec1[30:0], spi_mosi1};
        if (tx_done1) done_cnt1++;
        prev_sclk1 = spi_clk1;
        prev_cs1   = spi_cs_n1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [23:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 500 && !tx_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx_done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_ready) break;
        end
    endtask

    typedef struct {
        logic [23:0] data;
        logic [23:0] exp_dec;
        int          exp_low;
    } vec_t;

    vec_t vecs[4];
    bit   ok;
    int   d0, r0;

    initial begin
        vecs[0] = '{24'hC1C2C3, 24'hC1C2C3, 153};
        vecs[1] = '{24'h000000, 24'h000000, 153};
        vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 153};
        vecs[3] = '{24'hA55A01, 24'hA55A01, 153};

        reset = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_valid1 = 1'b0; tx_data1 = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sclk", spi_clk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_rx_data", rx_data, 0);
        reset = 1'b0;

        // Table-driven frames; tx_data is inverted right after accept
        for (int v = 0; v < 4; v++) begin
            d0 = done_cnt;
            send(vecs[v].data);
            @(negedge clk);
            check("ready_low_after_accept", tx_ready, 0);
            wait_done(ok);
            check("done_seen", ok, 1);
            check("rx_data_at_done", rx_data, RX_EXP);
            check("cs_n_at_done", spi_cs_n, 1);
            check("mosi_at_done", spi_mosi, 0);
            wait_ready();
            check("decoded", dec[23:0], vecs[v].exp_dec);
            check("cs_low_cycles", last_low, vecs[v].exp_low);
            check("done_pulses", done_cnt - d0, 1);
        end

        // tx_valid held high: two frames, guard plus one idle cycle between them
        d0 = done_cnt;
        @(negedge clk);
        tx_data = 24'h123456; tx_valid = 1'b1;
        wait_done(ok);
        check("b2b_done1", ok, 1);
        wait_done(ok);
        check("b2b_done2", ok, 1);
        tx_valid = 1'b0;
        wait_ready();
        repeat (5) @(negedge clk);
        check("b2b_gap_cycles", last_high, 4);
        check("b2b_done_pulses", done_cnt - d0, 2);
        check("b2b_ready_in_frame", ready_bad, 0);
        check("b2b_decoded", dec[23:0], 24'h123456);
        check("b2b_cs_low", last_low, 153);

        // Reset during the 40th cycle of a frame
        send(24'hC1C2C3);
        d0 = done_cnt;
        repeat (39) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx_ready", tx_ready, 1);
        check("abort_cs_n", spi_cs_n, 1);
        check("abort_sclk", spi_clk, 0);
        check("abort_mosi", spi_mosi, 0);
        check("abort_tx_done", tx_done, 0);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        send(24'h0F1E2D);
        wait_done(ok);
        check("fresh_done", ok, 1);
        wait_ready();
        check("fresh_decoded", dec[23:0], 24'h0F1E2D);
        check("fresh_cs_low", last_low, 153);

        // One-byte frame at CLK_DIV=1
        d0 = done_cnt1;
        r0 = rise_cnt1;
        @(negedge clk);
        tx_data1 = 8'hA5; tx_valid1 = 1'b1;
        for (int i = 0; i < 100 && !tx_ready1; i++) @(negedge clk);
        @(posedge clk);
        #1 tx_valid1 = 1'b0; tx_data1 = 8'h00;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_ready1) break;
        end
        repeat (3) @(negedge clk);
        check("small_sclk_rises", rise_cnt1 - r0, 8);
        check("small_cs_low", last_low1, 17);
        check("small_decoded", dec1[7:0], 8'hA5);
        check("small_done_pulses", done_cnt1 - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
